// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-file arbiter.
// Optional lock feature: REGFILE_ARB_LOCK_EN.
package regfile_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        CAPTURE,
        RESP
    } arb_state_t;

    localparam int RF_DEPTH = 32;
    localparam int RF_DW    = 8;
    localparam int RF_AW    = 8;

endpackage

// File: rtl/regfile_arbiter_rr_pick.sv
// Combinational round-robin selector: first valid bit at or after ptr wins.
// Returns a one-hot grant, all zero when nothing is valid.
module rr_pick #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic [PW-1:0] idx;

    // Scan from farthest to nearest so the nearest valid bit is kept.
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = PW'((32'(ptr) + 32'(k)) % N);
            if (valid[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_arbiter.sv
// Valid/ready arbiter sharing one 32x8 register file among NREQ requesters.
// Define REGFILE_ARB_LOCK_EN to add req_lock for atomic read-modify-write.
import regfile_arb_pkg::*;

module regfile_arbiter #(
    parameter int NREQ     = 2,
    parameter int DEPTH    = RF_DEPTH,
    parameter int LOCK_MAX = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0]       req_we,
    input  logic [NREQ*RF_AW-1:0] req_addr,
    input  logic [NREQ*RF_DW-1:0] req_wdata,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [RF_DW-1:0]      rsp_data,
    output logic                  rsp_err,
    output logic [RF_AW-1:0]      rf_address,
    output logic [RF_DW-1:0]      rf_data_in,
    output logic                  rf_enable,
    input  logic [RF_DW-1:0]      rf_data_out
`ifdef REGFILE_ARB_LOCK_EN
    ,
    input  logic [NREQ-1:0]       req_lock
`endif
);

    localparam int GW = $clog2(NREQ);

    arb_state_t      state;
    logic [GW-1:0]   g;
    logic [GW-1:0]   ptr;
    logic [GW-1:0]   gi;
    logic [NREQ-1:0] pick_rr;
    logic [NREQ-1:0] pick;
    logic [RF_AW-1:0] sel_addr;
    logic [RF_DW-1:0] sel_wdata;
    logic            sel_we;
    logic            in_range;
    logic            en_q;
    logic            err_q;
    logic            idle_hs;
    logic            resp_hs;

    rr_pick #(
        .N  (NREQ),
        .PW (GW)
    ) u_pick (
        .valid (req_valid),
        .ptr   (ptr),
        .grant (pick_rr)
    );

`ifdef REGFILE_ARB_LOCK_EN
    logic        lock_pend;
    logic        lock_go;
    logic [15:0] lock_run;

    assign lock_go = lock_pend && req_valid[g];

    always_comb begin
        pick = pick_rr;
        if (lock_go) begin
            pick    = '0;
            pick[g] = 1'b1;
        end
    end

    // lock_run counts consecutive grants to g made under lock.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_pend <= 1'b0;
            lock_run  <= '0;
        end else if (idle_hs) begin
            lock_pend <= 1'b0;
            if (!lock_go)
                lock_run <= '0;
        end else if (resp_hs) begin
            if (req_lock[g] && 32'(lock_run) < LOCK_MAX - 1) begin
                lock_pend <= 1'b1;
                lock_run  <= lock_run + 16'd1;
            end else begin
                lock_pend <= 1'b0;
                lock_run  <= '0;
            end
        end
    end
`else
    assign pick = pick_rr;
`endif

    always_comb begin
        gi = '0;
        for (int k = 0; k < NREQ; k++)
            if (pick[k])
                gi = GW'(k);
    end

    assign sel_addr  = req_addr[gi*RF_AW +: RF_AW];
    assign sel_wdata = req_wdata[gi*RF_DW +: RF_DW];
    assign sel_we    = req_we[gi];
    assign in_range  = {24'd0, sel_addr} < 32'(DEPTH);

    assign idle_hs = (state == IDLE) && (|pick);
    assign resp_hs = (state == RESP) && rsp_ready[g];

    assign req_ready = (state == IDLE && rst_n) ? pick : '0;

    // Reset suppresses the strobe at once so no negedge write slips through.
    assign rf_enable = en_q & rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            g          <= '0;
            ptr        <= '0;
            en_q       <= 1'b0;
            err_q      <= 1'b0;
            rf_address <= '0;
            rf_data_in <= '0;
            rsp_valid  <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (idle_hs) begin
                        g          <= gi;
                        rf_address <= sel_addr;
                        rf_data_in <= sel_wdata;
                        en_q       <= sel_we & in_range;
                        err_q      <= ~in_range;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    en_q  <= 1'b0;
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    rsp_data     <= err_q ? '0 : rf_data_out;
                    rsp_err      <= err_q;
                    rsp_valid    <= '0;
                    rsp_valid[g] <= 1'b1;
                    state        <= RESP;
                end
                RESP: begin
                    if (rsp_ready[g]) begin
                        rsp_valid <= '0;
                        ptr       <= (32'(g) == NREQ - 1) ? '0 : g + GW'(1);
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a negedge-write register file model.
// Lock sequence runs only when REGFILE_ARB_LOCK_EN is defined.
module tb_regfile_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [7:0]  rsp_data;
    logic        rsp_err;
    logic [7:0]  rf_address;
    logic [7:0]  rf_data_in;
    logic        rf_enable;
    logic [7:0]  rf_data_out;
`ifdef REGFILE_ARB_LOCK_EN
    logic [1:0]  req_lock;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [32];

    always #5 clk = ~clk;

    always @(negedge clk)
        if (rf_enable)
            mem[rf_address[4:0]] <= rf_data_in;

    assign rf_data_out = mem[rf_address[4:0]];

    regfile_arbiter #(
        .NREQ     (2),
        .DEPTH    (32),
        .LOCK_MAX (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .rf_address  (rf_address),
        .rf_data_in  (rf_data_in),
        .rf_enable   (rf_enable),
        .rf_data_out (rf_data_out)
`ifdef REGFILE_ARB_LOCK_EN
        ,
        .req_lock    (req_lock)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated transaction; the rsp_ready is raised in the first RESP cycle.
    task automatic txn(input int r, input logic we, input logic [7:0] addr,
                       input logic [7:0] wd, input logic exp_en,
                       input logic [7:0] exp_data, input logic exp_err,
                       input string tag);
        logic [1:0] oh;
        oh = 2'b01 << r;
        req_valid = oh;
        req_we[r] = we;
        req_addr[r*8 +: 8] = addr;
        req_wdata[r*8 +: 8] = wd;
        #1;
        chk({tag, ".ready"}, 32'(req_ready), 32'(oh));
        tick();
        req_valid = '0;
        chk({tag, ".en_access"}, 32'(rf_enable), 32'(exp_en));
        tick();
        chk({tag, ".en_capture"}, 32'(rf_enable), 32'(0));
        chk({tag, ".early_valid"}, 32'(rsp_valid), 32'(0));
        tick();
        chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(oh));
        chk({tag, ".rsp_data"}, 32'(rsp_data), 32'(exp_data));
        chk({tag, ".rsp_err"}, 32'(rsp_err), 32'(exp_err));
        rsp_ready = oh;
        tick();
        chk({tag, ".rsp_drop"}, 32'(rsp_valid), 32'(0));
        rsp_ready = '0;
        req_we = '0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++)
            mem[i] = 8'(i) ^ 8'h5C;
        rst_n     = 1'b0;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = '0;
`ifdef REGFILE_ARB_LOCK_EN
        req_lock  = '0;
`endif
        tick();
        tick();
        chk("rst.req_ready", 32'(req_ready), 32'(0));
        chk("rst.rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst.rsp_data", 32'(rsp_data), 32'(0));
        chk("rst.rsp_err", 32'(rsp_err), 32'(0));
        chk("rst.rf_address", 32'(rf_address), 32'(0));
        chk("rst.rf_data_in", 32'(rf_data_in), 32'(0));
        chk("rst.rf_enable", 32'(rf_enable), 32'(0));
        rst_n = 1'b1;
        tick();

        txn(0, 1'b1, 8'd3, 8'hA5, 1'b1, 8'hA5, 1'b0, "wr3");
        txn(1, 1'b0, 8'd3, 8'h00, 1'b0, 8'hA5, 1'b0, "rd3");
        txn(0, 1'b0, 8'd40, 8'h00, 1'b0, 8'h00, 1'b1, "rd40");
        txn(1, 1'b1, 8'd32, 8'h77, 1'b0, 8'h00, 1'b1, "wr32");
        txn(0, 1'b0, 8'd31, 8'h00, 1'b0, 8'h43, 1'b0, "rd31");

        // Reset while the write to address 5 sits in ACCESS.
        req_valid = 2'b01;
        req_we = 2'b01;
        req_addr[7:0] = 8'd5;
        req_wdata[7:0] = 8'hEE;
        #1;
        chk("rstmid.ready", 32'(req_ready), 32'(1));
        tick();
        rst_n = 1'b0;
        req_valid = '0;
        req_we = '0;
        #1;
        chk("rstmid.en", 32'(rf_enable), 32'(0));
        tick();
        rst_n = 1'b1;
        chk("rstmid.mem5", 32'(mem[5]), 32'(8'h59));
        chk("rstmid.valid0", 32'(rsp_valid), 32'(0));
        tick();
        tick();
        chk("rstmid.valid2", 32'(rsp_valid), 32'(0));
        chk("rstmid.en2", 32'(rf_enable), 32'(0));
        txn(1, 1'b0, 8'd5, 8'h00, 1'b0, 8'h59, 1'b0, "rd5");

        // Both requesters valid: grants alternate starting at 0.
        req_valid = 2'b11;
        req_we = '0;
        req_addr = {8'd5, 8'd3};
        rsp_ready = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("alt.ready", 32'(req_ready), 32'(2'b01 << (k % 2)));
            tick();
            tick();
            tick();
            chk("alt.rsp_valid", 32'(rsp_valid), 32'(2'b01 << (k % 2)));
            chk("alt.rsp_data", 32'(rsp_data),
                (k % 2 == 0) ? 32'h A5 : 32'h59);
            tick();
        end
        req_valid = '0;
        rsp_ready = '0;
        tick();

`ifdef REGFILE_ARB_LOCK_EN
        // Fresh pointer: 0 first, then 1 locked for LOCK_MAX grants, then 0.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req_valid = 2'b11;
        req_lock = 2'b10;
        rsp_ready = 2'b11;
        #1;
        for (int k = 0; k < 10; k++) begin
            chk("lock.ready", 32'(req_ready),
                (k == 0 || k == 9) ? 32'd1 : 32'd2);
            tick();
            tick();
            tick();
            tick();
        end
        req_valid = '0;
        req_lock = '0;
        rsp_ready = '0;
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_arbiter.md
# regfile_arbiter

Shares the single 32×8 register file between up to four requesters (CPU datapath, program loader, debug port) with a valid/ready request and response handshake. Drives the file's address, write-data and write-enable inputs from registers and returns its read data. Every access is a write-then-readback or a pure read. Sits between the requesters and the register file; the register file itself is unchanged.

## Interface
- `NREQ`, 2: number of requesters, 2..4.
- `DEPTH`, 32: register-file entries; addresses ≥ DEPTH are rejected.
- `LOCK_MAX`, 8: maximum consecutive locked grants; used only with the lock feature.
- `clk` in 1: single clock; all state updates on posedge.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in NREQ: request pending, one bit per requester.
- `req_ready` out NREQ: request accepted this cycle, one-hot.
- `req_we` in NREQ: 1 = write, 0 = read.
- `req_addr` in NREQ×8: packed request addresses; requester i uses `[8i+7:8i]`.
- `req_wdata` in NREQ×8: packed write data.
- `rsp_valid` out NREQ: response ready, one-hot to the granted requester.
- `rsp_ready` in NREQ: response consumed.
- `rsp_data` out 8: read data, shared by all requesters.
- `rsp_err` out 1: address out of range.
- `rf_address` out 8: to register-file address.
- `rf_data_in` out 8: to register-file data input.
- `rf_enable` out 1: to register-file write enable.
- `rf_data_out` in 8: from register-file read data.
- `req_lock` in NREQ: present only with `REGFILE_ARB_LOCK_EN`.

## Operation
- FSM states: IDLE, ACCESS, CAPTURE, RESP.
- **IDLE**
  - The round-robin pick selects one valid requester; the first pick after reset favours requester 0.
  - `req_ready[g]` is high combinationally for the picked requester only.
  - On the handshake edge, register g, `rf_address`, `rf_data_in` and `rf_enable = req_we & in_range`, then go to ACCESS.
- **ACCESS**
  - The register file writes on the negedge inside this cycle.
  - It samples `rf_data_out` at the closing posedge.
  - Next state is CAPTURE.
- **CAPTURE**
  - `rf_enable` is cleared at entry.
  - At the closing edge, register `rsp_data` and set `rsp_valid[g]`, then go to RESP.
  - `rsp_data` is `rf_data_out`, or 0 if the address is out of range.
- **RESP**
  - Hold `rsp_valid[g]`, `rsp_data` and `rsp_err` until `rsp_ready[g]`.
  - On that edge clear `rsp_valid`, advance the round-robin pointer past g and return to IDLE.
- A write returns the newly written value in `rsp_data`, since readback follows the write.
- An out-of-range address (`req_addr[i] ≥ DEPTH`):
  - No write is issued and `rf_enable` stays 0.
  - `rsp_err = 1` and `rsp_data = 0`.
  - Latency is the same as a normal access.
- `rf_address` keeps its last value when idle, so no spurious write occurs.
- A requester that deasserts `req_valid` before `req_ready` is simply not picked; no error.

## Timing
- Reset values:
  - `req_ready = 0`, `rsp_valid = 0`, `rsp_data = 0`, `rsp_err = 0`.
  - `rf_address = 0`, `rf_data_in = 0`, `rf_enable = 0`.
  - State IDLE, round-robin pointer set to favour requester 0.
- Latency:
  - Request accepted at edge E0; `rsp_valid` rises after E2.
  - Minimum of 4 cycles per transaction, including the RESP/`rsp_ready` cycle.
- Reset mid-transaction:
  - Any state returns to IDLE at the reset edge and `rf_enable` is 0 from that edge.
  - No negedge write occurs after the reset edge, and the pending response is dropped.
- All requesters valid together: grant order rotates 0,1,2,…; no requester waits more than NREQ−1 transactions.
- A `rsp_ready` that arrives already high in the first RESP cycle is honoured; the response is valid for exactly one cycle.

## Configuration
- `REGFILE_ARB_LOCK_EN` defined:
  - The `req_lock` port exists.
  - If `req_lock[g]` is high at the RESP handshake, the next IDLE pick is forced to g when `req_valid[g]` is high; otherwise normal round-robin.
  - This gives atomic read-modify-write.
  - After LOCK_MAX consecutive locked grants the lock is ignored for one arbitration.
  - Lock is cleared by reset.
- Undefined: no `req_lock` port; pure round-robin.

## Structure
- Package `regfile_arb_pkg`:
  - State enum `arb_state_t`.
  - `RF_DEPTH = 32`, `RF_DW = 8`, `RF_AW = 8`.
- Sub-module `rr_pick`: combinational round-robin selector (valid vector + pointer → one-hot grant).

## Test plan
- Reset, then requester 0 writes 0xA5 to address 3 → `rf_enable` high for one cycle; `rsp_valid[0]` after E2 with `rsp_data = 0xA5`, `rsp_err = 0`.
- Requester 1 reads address 3 after that write → `rsp_data = 0xA5`; `rf_enable` never asserted.
- Requesters 0 and 1 both valid continuously → grants alternate 0,1,0,1; each response delivered to the correct one-hot `rsp_valid`.
- Requester 0 reads address 40 → `rsp_err = 1`, `rsp_data = 0`, `rf_enable` stays 0, 4-cycle latency.
- `rst_n` low during ACCESS of a write to address 5 → FSM in IDLE next cycle, no `rsp_valid`; address 5 unchanged on readback.
- With `REGFILE_ARB_LOCK_EN`, requester 1 holds `req_lock` with requester 0 valid → requester 1 receives 8 consecutive grants, then requester 0 is granted.
